// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets NREQ requesters set or clear flags in a shared
// SR flag bank. At most one operation is applied every two cycles.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_set,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      grant,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy,
  output logic [7:0]           conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, win, win_q;
  logic [NREQ-1:0] win_oh;
  logic            any_req, arb, conflict;
  logic            op_set_q;
  logic [IDXW-1:0] op_idx_q;
  logic [NFLAG-1:0] s_vec, r_vec;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of always_ff ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Descending scan that overwrites: the last hit is the first valid requester
  // found searching upward from rr_ptr with wrap.
  always_comb begin
    int cand;
    win     = rr_ptr;
    any_req = |req_valid;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid[cand]) win = PW'(cand);
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            req_idx[i*IDXW +: IDXW] == req_idx[j*IDXW +: IDXW] &&
            req_set[i] != req_set[j])
          conflict = 1'b1;
      end
    end
  end

  assign arb = (state == IDLE) && any_req;

  // The operation is captured at the arbitration edge, so requester changes
  // during APPLY cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q        <= '0;
      op_set_q     <= 1'b0;
      op_idx_q     <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      conflict_cnt <= '0;
    end else begin
      grant <= '0;
      if (arb) begin
        win_q    <= win;
        op_set_q <= req_set[win];
        op_idx_q <= req_idx[win*IDXW +: IDXW];
        grant    <= win_oh;
        if (conflict && conflict_cnt != 8'hFF)
          conflict_cnt <= conflict_cnt + 8'd1;
      end
      if (state == APPLY)
        rr_ptr <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
    end
  end

  // s and r come from one latched bit and are mutually exclusive; an index
  // beyond the bank matches no flag, so nothing changes.
  always_comb begin
    busy  = 1'b0;
    s_vec = '0;
    r_vec = '0;
    if (state == APPLY) begin
      busy = 1'b1;
      for (int f = 0; f < NFLAG; f++) begin
        if (int'(op_idx_q) == f) begin
          s_vec[f] = op_set_q;
          r_vec[f] = !op_set_q;
        end
      end
    end
  end

  // NOTE: the flag bank is plain flops, not a memory, so it is reset like any
  // other state; an async reset mid-APPLY therefore drops the pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= (flags | s_vec) & ~r_vec;
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: directed requests queue expected
// grant/flags/conflict results, a monitor pops them as grants appear.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_set;
  logic [11:0] req_idx;
  logic [3:0]  grant;
  logic [7:0]  flags;
  logic        busy;
  logic [7:0]  conflict_cnt;

  logic [3:0]  b_valid, b_set;
  logic [11:0] b_idx;
  logic [3:0]  b_grant;
  logic [5:0]  b_flags;
  logic        b_busy;
  logic [7:0]  b_cnt;

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;

  typedef struct {
    logic [3:0] g;
    logic [7:0] f;
    logic [7:0] c;
  } exp_t;

  exp_t sb_q[$];

  sr_flag_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set),
    .req_idx(req_idx), .grant(grant), .flags(flags), .busy(busy),
    .conflict_cnt(conflict_cnt)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_set(b_set),
    .req_idx(b_idx), .grant(b_grant), .flags(b_flags), .busy(b_busy),
    .conflict_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] f, input logic [7:0] c);
    exp_t e;
    e.g = g; e.f = f; e.c = c;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int r, input bit s, input int idx);
    req_valid[r]       = 1'b1;
    req_set[r]         = s;
    req_idx[r*3 +: 3]  = 3'(idx);
  endtask

  task automatic b_req(input int r, input bit s, input int idx);
    b_valid[r]      = 1'b1;
    b_set[r]        = s;
    b_idx[r*3 +: 3] = 3'(idx);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // Plays the requester side: drops a requester's valid on the edge ending its
  // grant (if drop), and all valids after the last expected grant.
  task automatic serve(input int ngrants, input bit drop);
    int n = 0;
    int cyc = 0;
    int last = 0;
    logic [3:0] g;
    while (n < ngrants && cyc < ngrants * 4 + 8) begin
      @(negedge clk);
      cyc++;
      if (grant != 4'b0) begin
        n++;
        if (n == 1) check("first_latency", cyc, 1);
        else        check("grant_spacing", cyc - last, 2);
        last = cyc;
        g = grant;
        @(posedge clk);
        #1;
        if (n == ngrants) req_valid = '0;
        else if (drop)    req_valid = req_valid & ~g;
      end
    end
    check("grant_count", n, ngrants);
    if (n != ngrants) req_valid = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_en && grant != 4'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got %0h expected none", grant);
        end else begin
          e = sb_q.pop_front();
          check("grant", grant, e.g);
          check("busy_in_apply", busy, 1);
          check("conflict_cnt", conflict_cnt, e.c);
          @(negedge clk);
          check("flags_after", flags, e.f);
          check("busy_after", busy, 0);
          check("grant_after", grant, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    req_valid = '0; req_set = '0; req_idx = '0;
    b_valid = '0; b_set = '0; b_idx = '0;
    #12;
    check("rst_flags", flags, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", conflict_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_grant", grant, 0);
    check("idle_flags", flags, 0);
    check("idle_busy", busy, 0);
    sb_en = 1'b1;

    // Requester 1 sets flag 5.
    push(4'b0010, 8'h20, 8'd0);
    set_req(1, 1'b1, 5);
    serve(1, 1'b1);
    settle();

    // Four requesters set flags 0..3; then two more show rr_ptr wrapped to 0.
    apply_reset();
    push(4'b0001, 8'h01, 8'd0);
    push(4'b0010, 8'h03, 8'd0);
    push(4'b0100, 8'h07, 8'd0);
    push(4'b1000, 8'h0F, 8'd0);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, i);
    serve(4, 1'b1);
    settle();
    push(4'b0001, 8'h1F, 8'd0);
    push(4'b0010, 8'h3F, 8'd0);
    set_req(0, 1'b1, 4);
    set_req(1, 1'b1, 5);
    serve(2, 1'b1);
    settle();

    // Set/clear conflict on flag 2.
    apply_reset();
    push(4'b0001, 8'h04, 8'd1);
    push(4'b0100, 8'h00, 8'd1);
    set_req(0, 1'b1, 2);
    set_req(2, 1'b0, 2);
    serve(2, 1'b1);
    settle();

    // 300 conflicting arbitrations: counter saturates at 255.
    apply_reset();
    for (int k = 1; k <= 300; k++)
      push((k % 2 == 1) ? 4'b0001 : 4'b0010, (k % 2 == 1) ? 8'h08 : 8'h00,
           (k < 255) ? 8'(k) : 8'd255);
    set_req(0, 1'b1, 3);
    set_req(1, 1'b0, 3);
    serve(300, 1'b0);
    settle();
    check("cnt_saturated", conflict_cnt, 255);
    sb_en = 1'b0;

    // Async reset in the middle of APPLY drops the pending set of flag 7.
    apply_reset();
    set_req(0, 1'b1, 7);
    @(negedge clk);
    check("abort_grant_before", grant, 4'b0001);
    check("abort_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_flags", flags, 0);
    check("abort_grant", grant, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", conflict_cnt, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_flag7_stays", flags, 0);

    // NFLAG=6 instance: index 7 is granted but changes nothing.
    b_req(0, 1'b1, 2);
    @(negedge clk);
    check("b_grant0", b_grant, 4'b0001);
    @(posedge clk);
    #1;
    b_valid = '0;
    @(negedge clk);
    check("b_flags_set2", b_flags, 6'h04);
    b_req(3, 1'b1, 7);
    @(negedge clk);
    check("b_grant3", b_grant, 4'b1000);
    check("b_busy", b_busy, 1);
    @(posedge clk);
    #1;
    b_valid = '0;
    @(negedge clk);
    check("b_flags_oob", b_flags, 6'h04);
    check("b_busy_after", b_busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter NFLAG, default 8: number of SR status flags, 2..16.
REQ-003 Parameter IDXW, default 3: flag-index width, equal to clog2(NFLAG).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request.
REQ-007 req_set  input  NREQ  per-requester operation: 1 = set the flag, 0 = clear the flag.
REQ-008 req_idx  input  NREQ*IDXW  per-requester target flag index; requester i uses bits [i*IDXW +: IDXW].
REQ-009 grant  output  NREQ  registered one-hot pulse marking the requester whose operation is being applied.
REQ-010 flags  output  NFLAG  registered SR flag bank state.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 conflict_cnt  output  8  saturating count of detected set/clear conflicts.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and APPLY.
REQ-014 In IDLE with no req_valid bit set, the FSM SHALL remain in IDLE and leave flags, grant (all 0) and the pointer unchanged.
REQ-015 In IDLE with any req_valid bit set, the FSM SHALL choose a winner round-robin and enter APPLY on the next edge.
  - Search starts at pointer rr_ptr and ascends with wrap.
  - The winner's index and operation SHALL be latched at that edge.
REQ-016 In APPLY, grant SHALL equal one-hot(winner) for exactly one cycle; all other cycles grant = 0.
REQ-017 In APPLY, the latched operation SHALL be applied to flags[idx] at the APPLY-exiting edge.
  - Set: s=1, r=0 → flag becomes 1.
  - Clear: s=0, r=1 → flag becomes 0.
  - All other flags hold (s=0, r=0).
REQ-018 The combination s=1, r=1 SHALL never be generated; flags SHALL never take X.
REQ-019 On leaving APPLY, rr_ptr SHALL become (winner+1) mod NREQ and the FSM SHALL return to IDLE.
REQ-020 Operations SHALL be applied at most one every 2 cycles. Latency from req_valid sampled in IDLE to the flags update SHALL be 2 edges.
REQ-021 A requester SHALL hold req_valid, req_set and req_idx stable until it sees grant. It SHALL deassert req_valid on the edge ending its grant cycle, or it is rearbitrated as a new request.
REQ-022 Changes to req_* while in APPLY SHALL have no effect on the operation in progress.
REQ-023 A conflict is detected in IDLE at the arbitration edge when two or more valid requesters target the same req_idx with differing req_set.
  - On a conflict, conflict_cnt SHALL increment by 1, saturating at 255.
  - The winner is still chosen by REQ-015, and the losers remain pending.
REQ-024 A req_idx value of NFLAG or greater SHALL be granted but SHALL leave flags unchanged.
REQ-025 busy SHALL be 1 exactly in the APPLY state.

Reset
REQ-026 While rst=1, the block SHALL immediately, without waiting for clk, force all of the following: state = IDLE, rr_ptr = 0, grant = 0, flags = 0, busy = 0, conflict_cnt = 0.
REQ-027 Reset asserted during APPLY SHALL abort the operation, so the pending flag update is not applied.
REQ-028 The first arbitration SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-029 Reset, then requester 1 sets flag 5 → grant = 0b0010 on the cycle after sampling, flags = 0x20 one edge later, busy high for 1 cycle.
REQ-030 All 4 requesters held valid, setting flags 0..3 respectively → grants issued in the order 0,1,2,3, one every 2 cycles, final flags = 0x0F, rr_ptr wraps to 0.
REQ-031 Requester 0 sets flag 2 and requester 2 clears flag 2 simultaneously → conflict_cnt = 1; requester 0 granted first (flag2 = 1), then requester 2 (flag2 = 0).
REQ-032 Apply 300 conflicting arbitrations → conflict_cnt saturates at 255, with no wrap to 0.
REQ-033 rst pulsed asynchronously mid-APPLY with a set of flag 7 pending → flags = 0x00, grant = 0, busy = 0 immediately, and flag 7 stays 0 after release.
REQ-034 Requester 3 with req_idx = 7 while NFLAG = 6 → grant = 0b1000 is issued and flags are unchanged.
